// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and instruction prefetch buffer
// feeding the IF/ID register over a valid/ready handshake.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 16,
  parameter int INST_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic                         imem_ack,
  input  logic [INST_W-1:0]            imem_data,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INST_W-1:0]            out_inst,
  output logic [PC_W-1:0]              out_pc_plus1,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0]   r_pc;
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [PC_W-1:0]   r_pcp1 [DEPTH];

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [PC_W-1:0]   w_pc_nxt;

  assign w_full    = (r_count == FULL);
  assign imem_req  = rst && !redirect && !w_full;
  assign imem_addr = r_pc;
  assign w_push    = imem_req && imem_ack;
  assign w_pop     = out_valid && out_ready;
  assign w_pc_nxt  = r_pc + PC_ONE;

  assign out_valid    = (r_count != '0);
  assign out_inst     = out_valid ? r_inst[r_head] : '0;
  assign out_pc_plus1 = out_valid ? r_pcp1[r_head] : '0;
  assign count        = r_count;

  // Redirect wins over any coincident push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + P_ONE;
        r_pc   <= w_pc_nxt;
      end
      if (w_pop) begin
        r_head <= r_head + P_ONE;
      end
      unique case (1'b1)
        (w_push && !w_pop): r_count <= r_count + C_ONE;
        (!w_push && w_pop): r_count <= r_count - C_ONE;
        default:            r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_tail] <= imem_data;
      r_pcp1[r_tail] <= w_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue
// with a bench-side PC and queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] RPC = 16'h0000;

  typedef struct packed {
    logic [15:0] pcp1;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [15:0] out_pc_plus1;
  logic [2:0]  count;

  int   n_chk = 0;
  int   n_pass = 0;
  logic [15:0] m_pc = RPC;
  exp_t sb[$];

  fetch_queue #(
    .DEPTH(4), .PC_W(16), .INST_W(32), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc_plus1(out_pc_plus1),
    .count(count)
  );

  always #5 clk = ~clk;

  // mem[a] = 0x1000_0000 + a
  always_comb imem_data = 32'h1000_0000 + {16'h0, imem_addr};

  // Advance one clock and update the bench model from the driven inputs.
  task automatic tick();
    logic req, push, pop;
    exp_t e;
    req  = rst && !redirect && (sb.size() != DEPTH);
    push = req && imem_ack;
    pop  = (sb.size() != 0) && out_ready;
    @(posedge clk);
    if (redirect) begin
      sb.delete();
      m_pc = redirect_pc;
    end else begin
      if (pop) e = sb.pop_front();
      if (push) begin
        e.pcp1 = m_pc + 16'd1;
        e.inst = 32'h1000_0000 + {16'h0, m_pc};
        sb.push_back(e);
        m_pc = m_pc + 16'd1;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic flush(input logic [15:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    imem_ack = 1'b0;
    out_ready = 1'b0;
    tick();
    redirect = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", out_inst); else n_pass++;
    n_chk++; if (out_pc_plus1 !== 16'h0) $display("FAIL rst_pcp1: got %h want 0", out_pc_plus1); else n_pass++;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
    n_chk++; if (imem_addr !== RPC) $display("FAIL rst_addr: got %h want %h", imem_addr, RPC); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_pc = RPC;
    #1;
  endtask

  task automatic test_stream();
    imem_ack = 1'b1;
    out_ready = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL str_empty: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (imem_req !== 1'b1) $display("FAIL str_req: got %b want 1", imem_req); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL str_first_v: got %b want 1", out_valid); else n_pass++;
    n_chk++; if (out_inst !== 32'h1000_0000) $display("FAIL str_first_i: got %h want 10000000", out_inst); else n_pass++;
    n_chk++; if (out_pc_plus1 !== 16'h0001) $display("FAIL str_first_p: got %h want 0001", out_pc_plus1); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (count !== 3'd1) $display("FAIL str_count[%0d]: got %0d want 1", i, count); else n_pass++;
      n_chk++; if (imem_addr !== m_pc) $display("FAIL str_addr[%0d]: got %h want %h", i, imem_addr, m_pc); else n_pass++;
      if (sb.size() != 0) begin
        n_chk++; if (out_inst !== sb[0].inst) $display("FAIL str_inst[%0d]: got %h want %h", i, out_inst, sb[0].inst); else n_pass++;
        n_chk++; if (out_pc_plus1 !== sb[0].pcp1) $display("FAIL str_pcp1[%0d]: got %h want %h", i, out_pc_plus1, sb[0].pcp1); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    flush(16'h0000);
    imem_ack = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (count !== 3'(i + 1)) $display("FAIL stall_count[%0d]: got %0d want %0d", i, count, i + 1); else n_pass++;
    end
    n_chk++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %b want 0", imem_req); else n_pass++;
    n_chk++; if (imem_addr !== 16'h0004) $display("FAIL stall_pc: got %h want 0004", imem_addr); else n_pass++;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (out_inst !== 32'h1000_0000 + 32'(i)) $display("FAIL drain_inst[%0d]: got %h want %h", i, out_inst, 32'h1000_0000 + 32'(i)); else n_pass++;
      n_chk++; if (sb.size() == 0 || out_inst !== sb[0].inst) $display("FAIL drain_sb[%0d]: got %h", i, out_inst); else n_pass++;
      if (i == 1) begin
        n_chk++; if (imem_req !== 1'b1) $display("FAIL drain_req: got %b want 1", imem_req); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    flush(16'h0000);
    imem_ack = 1'b1;
    #1;
    repeat (3) tick();
    n_chk++; if (count !== 3'd3) $display("FAIL redir_pre: got %0d want 3", count); else n_pass++;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    out_ready = 1'b1;
    #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL redir_req0: got %b want 0", imem_req); else n_pass++;
    tick();
    redirect = 1'b0;
    #1;
    n_chk++; if (count !== 3'd0) $display("FAIL redir_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (imem_addr !== 16'h0040) $display("FAIL redir_addr: got %h want 0040", imem_addr); else n_pass++;
    n_chk++; if (imem_req !== 1'b1) $display("FAIL redir_req1: got %b want 1", imem_req); else n_pass++;
    tick();
    n_chk++; if (out_inst !== 32'h1000_0040) $display("FAIL redir_inst: got %h want 10000040", out_inst); else n_pass++;
    n_chk++; if (out_pc_plus1 !== 16'h0041) $display("FAIL redir_pcp1: got %h want 0041", out_pc_plus1); else n_pass++;
    n_chk++; if (sb.size() == 0 || out_inst !== sb[0].inst) $display("FAIL redir_sb: got %h", out_inst); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] wa [3];
    logic [15:0] wp [3];
    wa = '{16'hFFFE, 16'hFFFF, 16'h0000};
    wp = '{16'hFFFF, 16'h0000, 16'h0001};
    flush(16'hFFFE);
    imem_ack = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (imem_addr !== wa[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, imem_addr, wa[i]); else n_pass++;
      if (i > 0) begin
        n_chk++; if (out_pc_plus1 !== wp[i-1]) $display("FAIL wrap_pcp1[%0d]: got %h want %h", i, out_pc_plus1, wp[i-1]); else n_pass++;
      end
      tick();
    end
    n_chk++; if (out_pc_plus1 !== wp[2]) $display("FAIL wrap_pcp1[3]: got %h want %h", out_pc_plus1, wp[2]); else n_pass++;
    n_chk++; if (sb.size() == 0 || out_pc_plus1 !== sb[0].pcp1) $display("FAIL wrap_sb: got %h", out_pc_plus1); else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [3:0] pat;
    pat = 4'b1001;
    flush(16'h0000);
    for (int i = 0; i < 4; i++) begin
      imem_ack = pat[i];
      #1;
      if (i > 0) begin
        n_chk++; if (imem_addr !== 16'h0001) $display("FAIL wait_addr[%0d]: got %h want 0001", i, imem_addr); else n_pass++;
      end
      tick();
    end
    n_chk++; if (count !== 3'd2) $display("FAIL wait_count: got %0d want 2", count); else n_pass++;
    imem_ack = 1'b0;
    out_ready = 1'b1;
    #1;
    n_chk++; if (out_inst !== 32'h1000_0000) $display("FAIL wait_e0: got %h want 10000000", out_inst); else n_pass++;
    tick();
    n_chk++; if (out_inst !== 32'h1000_0001) $display("FAIL wait_e1: got %h want 10000001", out_inst); else n_pass++;
    n_chk++; if (sb.size() == 0 || out_inst !== sb[0].inst) $display("FAIL wait_sb: got %h", out_inst); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL wait_empty: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_async_reset();
    flush(16'h0000);
    imem_ack = 1'b1;
    #1;
    tick();
    tick();
    n_chk++; if (count !== 3'd2) $display("FAIL ares_pre: got %0d want 2", count); else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_chk++; if (count !== 3'd0) $display("FAIL ares_count: got %0d want 0", count); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ares_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL ares_req: got %b want 0", imem_req); else n_pass++;
    sb.delete();
    m_pc = RPC;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (imem_addr !== RPC) $display("FAIL ares_addr: got %h want %h", imem_addr, RPC); else n_pass++;
    n_chk++; if (imem_req !== 1'b1) $display("FAIL ares_req1: got %b want 1", imem_req); else n_pass++;
    tick();
    n_chk++; if (out_inst !== 32'h1000_0000) $display("FAIL ares_inst: got %h want 10000000", out_inst); else n_pass++;
    n_chk++; if (out_pc_plus1 !== 16'h0001) $display("FAIL ares_pcp1: got %h want 0001", out_pc_plus1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_wait_states();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
